// File: rtl/tick_timer_pkg.sv
// Shared clocking package: FSM encoding and tap-select width for the tick timer.
// No logic; no latency or flow-control concerns.
package tick_timer_pkg;
  localparam int SEL_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/tick_timer_if.sv
// Control/status bundle of the tick timer; master drives taps, select and commands.
// Pure wiring: no latency, no backpressure.
interface tick_timer_if import tick_timer_pkg::*; #(
  parameter int SIZE  = 36,
  parameter int CNT_W = 16
);
  logic [SIZE:0]      CLKS_in;
  logic [SEL_W-1:0]   SEL_in;
  logic [CNT_W-1:0]   LOAD_in;
  logic               START_in;
  logic               STOP_in;
  logic               TICK_out;
  logic               BUSY_out;
  logic               DONE_out;
  logic [CNT_W-1:0]   COUNT_out;

  modport master (
    output CLKS_in, SEL_in, LOAD_in, START_in, STOP_in,
    input  TICK_out, BUSY_out, DONE_out, COUNT_out
  );

  modport slave (
    input  CLKS_in, SEL_in, LOAD_in, START_in, STOP_in,
    output TICK_out, BUSY_out, DONE_out, COUNT_out
  );
endinterface

// File: rtl/tick_timer_tap_tick.sv
// Rising-edge detector on a selectable divider tap; tick lags the tap sample by 2 cycles.
// No backpressure: one-cycle pulse per tap rise, masked for 2 cycles after a select change.
module tap_tick import tick_timer_pkg::*; #(
  parameter int SIZE = 36
) (
  input  logic             CLK_in,
  input  logic             RST_in,
  input  logic [SIZE:0]    CLKS_in,
  input  logic [SEL_W-1:0] SEL_in,
  output logic             TICK_out
);
  logic [SEL_W-1:0] sel_q;
  logic [1:0]       sup_q;
  logic             tap_q;
  logic             prev_q;
  logic             tap_d;
  logic             tick_d;
  logic             sel_chg;

  assign sel_chg = (SEL_in != sel_q);

  // Tap 0 is the clock itself and out-of-range taps read as a flat low line.
  always_comb begin
    tap_d  = 1'b0;
    tick_d = 1'b0;
    if (sel_q != '0 && int'(sel_q) <= SIZE) begin
      tap_d = CLKS_in[sel_q];
    end
    // The two masked cycles cover the edge pair that mixes old- and new-tap samples.
    if (sup_q == 2'd0) begin
      tick_d = (sel_q == '0) ? 1'b1 : (tap_q & ~prev_q);
    end
  end

  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      sel_q    <= '0;
      sup_q    <= 2'd0;
      tap_q    <= 1'b0;
      prev_q   <= 1'b0;
      TICK_out <= 1'b0;
    end else begin
      sel_q    <= SEL_in;
      tap_q    <= tap_d;
      prev_q   <= tap_q;
      TICK_out <= tick_d;
      if (sel_chg) begin
        sup_q <= 2'd2;
      end else if (sup_q != 2'd0) begin
        sup_q <= sup_q - 2'd1;
      end
    end
  end
endmodule

// File: rtl/tick_timer.sv
// Down-counting tick timer: loads a count, decrements per tap tick, pulses DONE at zero.
// Status outputs are registered-state decodes; commands take effect at the next edge.
module tick_timer import tick_timer_pkg::*; #(
  parameter int SIZE  = 36,
  parameter int CNT_W = 16
) (
  input  logic        CLK_in,
  input  logic        RST_in,
  tick_timer_if.slave bus
);
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick;
  logic             start_go;

  tap_tick #(.SIZE(SIZE)) u_tap_tick (
    .CLK_in   (CLK_in),
    .RST_in   (RST_in),
    .CLKS_in  (bus.CLKS_in),
    .SEL_in   (bus.SEL_in),
    .TICK_out (tick)
  );

  assign start_go = bus.START_in & ~bus.STOP_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (bus.STOP_in) begin
          state_d = IDLE;
        end else if (bus.START_in) begin
          if (bus.LOAD_in != '0) cnt_d = bus.LOAD_in;
          else                   state_d = FIN;
        end else if (tick && cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIN;
        end
      end
      IDLE, FIN: begin
        // FIN always falls back to IDLE unless a start chains the next run.
        if (state_q == FIN) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        if (start_go) begin
          if (bus.LOAD_in != '0) begin
            cnt_d   = bus.LOAD_in;
            state_d = RUN;
          end else begin
            state_d = FIN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.TICK_out  = tick;
  assign bus.BUSY_out  = (state_q == RUN);
  assign bus.DONE_out  = (state_q == FIN);
  // A zero-load restart can reach FIN with a stale count; FIN always reports zero.
  assign bus.COUNT_out = (state_q == FIN) ? '0 : cnt_q;
endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: FSM vector table with ticks disabled, then tick sequences.
// Free-running divider drives the tap bus; outputs sampled 1 time unit after each edge.
module tb_tick_timer;
  import tick_timer_pkg::*;

  localparam int SIZE  = 36;
  localparam int CNT_W = 16;

  logic            CLK_in = 1'b0;
  logic            RST_in = 1'b1;
  logic [SIZE-1:0] div_cnt = '0;
  int              tests = 0;
  int              fails = 0;

  typedef struct {
    logic             rst;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] load;
    logic             exp_tick;
    logic             exp_busy;
    logic             exp_done;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  tick_timer_if #(.SIZE(SIZE), .CNT_W(CNT_W)) bus ();

  tick_timer #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .CLK_in (CLK_in),
    .RST_in (RST_in),
    .bus    (bus)
  );

  always #5 CLK_in = ~CLK_in;
  always @(posedge CLK_in) div_cnt <= div_cnt + 1'b1;
  // Bit i of the tap bus has a period of 2^i cycles.
  assign bus.CLKS_in = {div_cnt, 1'b0};

  task automatic step();
    @(posedge CLK_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Looks at the current cycle first, then steps until a tick is visible or the budget runs out.
  task automatic wait_tick(input int max, output logic seen, output int n);
    seen = bus.TICK_out;
    n = 0;
    while (!seen && n < max) begin
      step();
      n++;
      seen = bus.TICK_out;
    end
  endtask

  task automatic do_reset(input logic [SEL_W-1:0] sel);
    RST_in       = 1'b1;
    bus.START_in = 1'b0;
    bus.STOP_in  = 1'b0;
    bus.SEL_in   = sel;
    step();
    RST_in = 1'b0;
    repeat (3) step();
  endtask

  task automatic start_run(input logic [CNT_W-1:0] load);
    bus.LOAD_in  = load;
    bus.START_in = 1'b1;
    step();
    bus.START_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    int   n;
    int   cnt_ticks;

    bus.SEL_in   = 6'd40;
    bus.LOAD_in  = '0;
    bus.START_in = 1'b0;
    bus.STOP_in  = 1'b0;

    // rst start stop load | tick busy done count   (SEL=40: no tap ticks)
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'd7, 1'b0, 1'b1, 1'b0, 16'd7});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd7});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, 16'd3});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'd9, 1'b0, 1'b0, 1'b0, 16'd3});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 16'd3});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 16'd3});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'd4, 1'b0, 1'b1, 1'b0, 16'd4});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b1, 1'b0, 16'd2});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'd5, 1'b0, 1'b1, 1'b0, 16'd5});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 16'd5, 1'b0, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0});

    step();
    foreach (vecs[i]) begin
      RST_in       = vecs[i].rst;
      bus.START_in = vecs[i].start;
      bus.STOP_in  = vecs[i].stop;
      bus.LOAD_in  = vecs[i].load;
      step();
      check($sformatf("vec%0d tick", i), 32'(bus.TICK_out), 32'(vecs[i].exp_tick));
      check($sformatf("vec%0d busy", i), 32'(bus.BUSY_out), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d done", i), 32'(bus.DONE_out), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d count", i), 32'(bus.COUNT_out), 32'(vecs[i].exp_cnt));
    end
    bus.START_in = 1'b0;
    bus.STOP_in  = 1'b0;

    // SEL=3: one-cycle pulse every 8 cycles.
    do_reset(6'd3);
    wait_tick(40, seen, n);
    check("sel3 first tick", 32'(seen), 32'd1);
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 8; k++) begin
        step();
        check($sformatf("sel3 p%0d c%0d", p, k), 32'(bus.TICK_out), (k == 8) ? 32'd1 : 32'd0);
      end
    end

    // SEL=2, LOAD=5: five ticks 4 cycles apart, counted down, then DONE.
    do_reset(6'd2);
    start_run(16'd5);
    check("run5 busy at start", 32'(bus.BUSY_out), 32'd1);
    check("run5 count at start", 32'(bus.COUNT_out), 32'd5);
    for (int k = 0; k < 5; k++) begin
      wait_tick(10, seen, n);
      check($sformatf("run5 tick%0d seen", k), 32'(seen), 32'd1);
      if (k > 0) check($sformatf("run5 tick%0d gap", k), 32'(n + 1), 32'd4);
      check($sformatf("run5 tick%0d count", k), 32'(bus.COUNT_out), 32'(5 - k));
      check($sformatf("run5 tick%0d busy", k), 32'(bus.BUSY_out), 32'd1);
      step();
    end
    check("run5 done pulse", 32'(bus.DONE_out), 32'd1);
    check("run5 busy in fin", 32'(bus.BUSY_out), 32'd0);
    check("run5 count in fin", 32'(bus.COUNT_out), 32'd0);
    step();
    check("run5 done after fin", 32'(bus.DONE_out), 32'd0);
    check("run5 busy after fin", 32'(bus.BUSY_out), 32'd0);

    // SEL=1, LOAD=10: abort after four ticks keeps the remaining count.
    do_reset(6'd1);
    start_run(16'd10);
    for (int k = 0; k < 4; k++) begin
      wait_tick(6, seen, n);
      check($sformatf("stop tick%0d seen", k), 32'(seen), 32'd1);
      check($sformatf("stop tick%0d count", k), 32'(bus.COUNT_out), 32'(10 - k));
      step();
    end
    check("stop count before abort", 32'(bus.COUNT_out), 32'd6);
    bus.STOP_in = 1'b1;
    step();
    bus.STOP_in = 1'b0;
    check("stop busy", 32'(bus.BUSY_out), 32'd0);
    check("stop count held", 32'(bus.COUNT_out), 32'd6);
    check("stop no done", 32'(bus.DONE_out), 32'd0);
    step();
    check("stop no done later", 32'(bus.DONE_out), 32'd0);
    check("stop count still held", 32'(bus.COUNT_out), 32'd6);

    // SEL 4 -> 1 mid-run: masked window, then a tick every 2 cycles; SEL=40 stalls the run.
    do_reset(6'd4);
    start_run(16'd100);
    wait_tick(40, seen, n);
    check("sel4 tick seen", 32'(seen), 32'd1);
    bus.SEL_in = 6'd1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("selchg quiet%0d", k), 32'(bus.TICK_out), 32'd0);
    end
    wait_tick(3, seen, n);
    check("sel1 tick resumes", 32'(seen), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("sel1 alt%0d", k), 32'(bus.TICK_out), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.SEL_in = 6'd40;
    step();
    cnt_ticks = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.TICK_out) cnt_ticks++;
    end
    check("sel40 no ticks", 32'(cnt_ticks), 32'd0);
    check("sel40 busy held", 32'(bus.BUSY_out), 32'd1);
    check("sel40 no done", 32'(bus.DONE_out), 32'd0);
    bus.STOP_in = 1'b1;
    step();
    bus.STOP_in = 1'b0;
    check("sel40 stopped", 32'(bus.BUSY_out), 32'd0);

    // Reset mid-run with three ticks left.
    do_reset(6'd2);
    start_run(16'd5);
    for (int k = 0; k < 2; k++) begin
      wait_tick(10, seen, n);
      check($sformatf("rst tick%0d seen", k), 32'(seen), 32'd1);
      step();
    end
    check("rst count before", 32'(bus.COUNT_out), 32'd3);
    check("rst busy before", 32'(bus.BUSY_out), 32'd1);
    RST_in = 1'b1;
    step();
    check("rst tick", 32'(bus.TICK_out), 32'd0);
    check("rst busy", 32'(bus.BUSY_out), 32'd0);
    check("rst done", 32'(bus.DONE_out), 32'd0);
    check("rst count", 32'(bus.COUNT_out), 32'd0);
    RST_in = 1'b0;
    step();
    check("rst no done after", 32'(bus.DONE_out), 32'd0);
    check("rst idle after", 32'(bus.BUSY_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
